alu_shift_sequencer: RTL and testbench

Multi-cycle shift engine and sequencer for the SLL/SRL/SRA/SLLI/SRLI/SRAI operations. It replaces the single-cycle 32-bit barrel shifter in the execute stage.
- Decode/ALU control issues a shift operation with an operand and a shift amount.
- The block steps the shift over several cycles and holds the pipeline via `stall_o` until the result is ready.
- It sits beside the ALU in the execute stage and drives the execute-stage result mux when `done_o` is asserted.

---
 rtl/alu_shift_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_shift_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA engine for the execute stage. It steps the shift by
// FAST_STEP or by 1 each cycle and holds the pipeline until the result is ready.
module alu_shift_sequencer #(
    parameter int FAST_STEP = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_i,
    input  logic [4:0]  shamt_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        illegal_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;
    localparam logic [4:0] STEP   = 5'(FAST_STEP);

    state_t      state, state_next;
    logic [31:0] work, work_next;
    logic [31:0] result_next;
    logic [31:0] shifted;
    logic [63:0] fill_ext;
    logic [4:0]  cnt, cnt_next, cnt_dec, step_amt;
    logic [1:0]  op, op_next;
    logic        sign, sign_next;
    logic        illegal, illegal_next;

    // One shift step; SRA fills from the sign captured at accept time.
    always_comb begin
        step_amt = (cnt >= STEP) ? STEP : 5'd1;
        cnt_dec  = cnt - step_amt;
        fill_ext = {{32{(op == OP_SRA) && sign}}, work} >> step_amt;
        shifted  = (op == OP_SLL) ? (work << step_amt) : fill_ext[31:0];
    end

    always_comb begin
        state_next   = state;
        work_next    = work;
        cnt_next     = cnt;
        op_next      = op;
        sign_next    = sign;
        illegal_next = illegal;
        result_next  = result_o;
        case (state)
            IDLE: begin
                if (start_i && !flush_i) begin
                    work_next    = operand_i;
                    cnt_next     = shamt_i;
                    op_next      = op_i;
                    sign_next    = operand_i[31];
                    illegal_next = (op_i == OP_ILL);
                    if (op_i == OP_ILL) begin
                        state_next  = DONE;
                        result_next = '0;
                    end else if (shamt_i == '0) begin
                        state_next  = DONE;
                        result_next = operand_i;
                    end else begin
                        state_next  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // A flush abandons the shift without touching the committed result.
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    work_next = shifted;
                    cnt_next  = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_next  = DONE;
                        result_next = shifted;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= '0;
            op       <= '0;
            sign     <= 1'b0;
            illegal  <= 1'b0;
            result_o <= '0;
        end else begin
            state    <= state_next;
            work     <= work_next;
            cnt      <= cnt_next;
            op       <= op_next;
            sign     <= sign_next;
            illegal  <= illegal_next;
            result_o <= result_next;
        end
    end

    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign illegal_o = (state == DONE) && illegal;
    assign stall_o   = ((state == IDLE) && start_i && !flush_i) || (state == SHIFT);

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed self-checking bench for alu_shift_sequencer with FAST_STEP = 4.
module tb_alu_shift_sequencer;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] operand_i;
    logic [4:0]  shamt_i;
    logic        flush_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic        illegal_o;
    logic [31:0] result_o;

    int n_cmp;
    int n_fail;

    alu_shift_sequencer #(.FAST_STEP(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .operand_i (operand_i),
        .shamt_i   (shamt_i),
        .flush_i   (flush_i),
        .busy_o    (busy_o),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .illegal_o (illegal_o),
        .result_o  (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Issues one request at a negedge (cycle 0) and follows it until done_o,
    // recording the done cycle, result, illegal flag and stall/busy violations.
    task automatic run_op(input logic [1:0] op, input logic [31:0] operand,
                          input logic [4:0] shamt, output int done_cycle,
                          output logic [31:0] res, output logic ill,
                          output int stall_err, output int busy_err);
        @(negedge clk_i);
        op_i      = op;
        operand_i = operand;
        shamt_i   = shamt;
        start_i   = 1'b1;
        #1;
        stall_err  = 0;
        busy_err   = 0;
        done_cycle = -1;
        res        = 'x;
        ill        = 1'bx;
        if (stall_o !== 1'b1) stall_err++;
        if (busy_o !== 1'b0) busy_err++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            if (busy_o !== 1'b1) busy_err++;
            if (done_o === 1'b1) begin
                done_cycle = c;
                res        = result_o;
                ill        = illegal_o;
                if (stall_o !== 1'b0) stall_err++;
                break;
            end
            if (stall_o !== 1'b1) stall_err++;
        end
    endtask

    task automatic test_reset();
        rst_i     = 1'b1;
        start_i   = 1'b1;
        op_i      = 2'b00;
        operand_i = 32'h0000_0001;
        shamt_i   = 5'd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (result_o !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_result: got %h expected %h", result_o, 32'h0);
            end
            n_cmp++;
            if (done_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_done: got %b expected 0", done_o);
            end
            n_cmp++;
            if (busy_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_busy: got %b expected 0", busy_o);
            end
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_first_accept: busy got %b expected 1", busy_o);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        n_cmp++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_early_done: got %b expected 0", done_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (done_o !== 1'b1 || result_o !== 32'h0000_0020) begin
            n_fail++;
            $display("[TB] FAIL reset_first_result: done %b result %h expected done 1 result %h",
                     done_o, result_o, 32'h0000_0020);
        end
    endtask

    task automatic test_sll();
        int dc, se, be;
        logic [31:0] r;
        logic il;
        run_op(2'b00, 32'h0000_0001, 5'd5, dc, r, il, se, be);
        n_cmp++;
        if (dc !== 3) begin
            n_fail++;
            $display("[TB] FAIL sll5_done_cycle: got %0d expected 3", dc);
        end
        n_cmp++;
        if (r !== 32'h0000_0020) begin
            n_fail++;
            $display("[TB] FAIL sll5_result: got %h expected %h", r, 32'h0000_0020);
        end
        n_cmp++;
        if (se !== 0 || be !== 0) begin
            n_fail++;
            $display("[TB] FAIL sll5_stall_busy: stall errors %0d busy errors %0d expected 0 0", se, be);
        end
        @(negedge clk_i);
        n_cmp++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'h0000_0020) begin
            n_fail++;
            $display("[TB] FAIL sll5_after_done: done %b busy %b result %h expected 0 0 %h",
                     done_o, busy_o, result_o, 32'h0000_0020);
        end
        run_op(2'b00, 32'h0000_ABCD, 5'd4, dc, r, il, se, be);
        n_cmp++;
        if (dc !== 2 || r !== 32'h000A_BCD0) begin
            n_fail++;
            $display("[TB] FAIL sll4_exact_step: cycle %0d result %h expected 2 %h", dc, r, 32'h000A_BCD0);
        end
    endtask

    task automatic test_sra_srl();
        int dc, se, be;
        logic [31:0] r;
        logic il;
        run_op(2'b10, 32'h8000_0000, 5'd31, dc, r, il, se, be);
        n_cmp++;
        if (dc !== 11 || r !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("[TB] FAIL sra31: cycle %0d result %h expected 11 %h", dc, r, 32'hFFFF_FFFF);
        end
        n_cmp++;
        if (se !== 0 || be !== 0) begin
            n_fail++;
            $display("[TB] FAIL sra31_stall_busy: stall errors %0d busy errors %0d expected 0 0", se, be);
        end
        run_op(2'b01, 32'h8000_0000, 5'd31, dc, r, il, se, be);
        n_cmp++;
        if (dc !== 11 || r !== 32'h0000_0001) begin
            n_fail++;
            $display("[TB] FAIL srl31: cycle %0d result %h expected 11 %h", dc, r, 32'h0000_0001);
        end
        run_op(2'b10, 32'h8000_0010, 5'd3, dc, r, il, se, be);
        n_cmp++;
        if (dc !== 4 || r !== 32'hF000_0002) begin
            n_fail++;
            $display("[TB] FAIL sra3_single_steps: cycle %0d result %h expected 4 %h", dc, r, 32'hF000_0002);
        end
        run_op(2'b10, 32'h7FFF_0000, 5'd6, dc, r, il, se, be);
        n_cmp++;
        if (dc !== 4 || r !== 32'h01FF_FC00) begin
            n_fail++;
            $display("[TB] FAIL sra6_positive: cycle %0d result %h expected 4 %h", dc, r, 32'h01FF_FC00);
        end
    endtask

    task automatic test_zero_illegal();
        int dc, se, be;
        logic [31:0] r;
        logic il;
        run_op(2'b01, 32'hDEAD_BEEF, 5'd0, dc, r, il, se, be);
        n_cmp++;
        if (dc !== 1 || r !== 32'hDEAD_BEEF || il !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_shift: cycle %0d result %h illegal %b expected 1 %h 0",
                     dc, r, il, 32'hDEAD_BEEF);
        end
        run_op(2'b11, 32'h1234_5678, 5'd7, dc, r, il, se, be);
        n_cmp++;
        if (dc !== 1 || r !== 32'h0 || il !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL illegal_op: cycle %0d result %h illegal %b expected 1 %h 1", dc, r, il, 32'h0);
        end
        @(negedge clk_i);
        n_cmp++;
        if (illegal_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL illegal_pulse_width: got %b expected 0", illegal_o);
        end
    endtask

    task automatic test_flush();
        int dones;
        // flush together with start in IDLE drops the request
        @(negedge clk_i);
        op_i = 2'b00; operand_i = 32'h0000_0005; shamt_i = 5'd1;
        start_i = 1'b1; flush_i = 1'b1;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_idle_stall: got %b expected 0", stall_o);
        end
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_idle_dropped: busy got %b expected 0", busy_o);
        end
        // flush in DONE still delivers the result
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        n_cmp++;
        if (done_o !== 1'b1 || result_o !== 32'h0000_000A) begin
            n_fail++;
            $display("[TB] FAIL flush_in_done: done %b result %h expected 1 %h", done_o, result_o, 32'h0000_000A);
        end
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_in_done_idle: busy %b done %b expected 0 0", busy_o, done_o);
        end
        // flush mid-shift aborts without a result
        @(negedge clk_i);
        op_i = 2'b00; operand_i = 32'h0000_0001; shamt_i = 5'd20; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0000_000A) begin
            n_fail++;
            $display("[TB] FAIL flush_mid_shift: busy %b done %b result %h expected 0 0 %h",
                     busy_o, done_o, result_o, 32'h0000_000A);
        end
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_fail++;
            $display("[TB] FAIL flush_no_done: got %0d done pulses expected 0", dones);
        end
    endtask

    task automatic test_busy_start();
        int dones, first;
        @(negedge clk_i);
        op_i = 2'b00; operand_i = 32'h0000_0003; shamt_i = 5'd9; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        op_i = 2'b01; operand_i = 32'h0000_FFFF; shamt_i = 5'd1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        dones = 0;
        first = -1;
        for (int c = 3; c < 18; c++) begin
            #1;
            if (done_o === 1'b1) begin
                dones++;
                if (first < 0) first = c;
                n_cmp++;
                if (result_o !== 32'h0000_0600) begin
                    n_fail++;
                    $display("[TB] FAIL busy_start_result: got %h expected %h", result_o, 32'h0000_0600);
                end
            end
            @(negedge clk_i);
        end
        n_cmp++;
        if (dones !== 1 || first !== 4) begin
            n_fail++;
            $display("[TB] FAIL busy_start_ignored: done pulses %0d first cycle %0d expected 1 4", dones, first);
        end
    endtask

    task automatic test_mid_reset();
        int dc, se, be;
        logic [31:0] r;
        logic il;
        @(negedge clk_i);
        op_i = 2'b10; operand_i = 32'h8000_0000; shamt_i = 5'd31; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: busy %b done %b result %h expected 0 0 %h",
                     busy_o, done_o, result_o, 32'h0);
        end
        run_op(2'b00, 32'h0000_0003, 5'd1, dc, r, il, se, be);
        n_cmp++;
        if (dc !== 2 || r !== 32'h0000_0006) begin
            n_fail++;
            $display("[TB] FAIL post_reset_sll: cycle %0d result %h expected 2 %h", dc, r, 32'h0000_0006);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_i     = 1'b1;
        start_i   = 1'b0;
        flush_i   = 1'b0;
        op_i      = 2'b00;
        operand_i = 32'h0;
        shamt_i   = 5'd0;
        test_reset();
        test_sll();
        test_sra_srl();
        test_zero_illegal();
        test_flush();
        test_busy_start();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
